// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//   A BCD frame is captured into a pending register by 'load' and committed to
//   the display register only at the frame boundary, so a frame never mixes
//   digits from two different loads. Each digit slot starts with one
//   all-anodes-off guard cycle (anti-ghosting) followed by SCAN_DIV-1 lit
//   cycles.
//
// Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking). When
//   defined, a digit k>0 is blanked (bcd_out = 4'hF, anode still driven) if
//   display nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   digits_in  in   BCD frame, nibble k = digit k (digit 0 rightmost)
//   load       in   single-cycle strobe capturing digits_in into pending
//   digit_en   in   per-digit enable, 0 blanks that digit
//   bcd_out    out  BCD code for the decoder, 4'hF = blank
//   an         out  active-low digit selects, at most one low
//   frame_done out  one-cycle pulse after the last digit slot ends
module seg_scan_mux #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    GUARD = 1'b0,
    SCAN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic [4*DIGITS-1:0]   display_q, display_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nib [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib[gi] = display_q[4*gi +: 4];
  end

`ifdef SEG_SCAN_LZB_EN
  // zero_from[k] is high when nibbles k..DIGITS-1 of the display are all zero.
  logic [DIGITS-1:0] zero_from;
  logic              lzb_blank;

  assign zero_from[DIGITS-1] = (nib[DIGITS-1] == 4'h0);
  for (genvar gi = 0; gi < DIGITS - 1; gi++) begin : g_lzb
    assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
  end
  assign lzb_blank = (idx_q != '0) && zero_from[idx_q];
`endif

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    slot_end = (state_q == SCAN) && tick;
    wrap     = slot_end && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // GUARD always coincides with cnt == 0, so it lasts a single cycle.
    state_d = state_q;
    case (state_q)
      GUARD:   state_d = SCAN;
      SCAN:    if (tick) state_d = GUARD;
      default: state_d = GUARD;
    endcase

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    // A load on the wrap edge bypasses pending so the new frame shows at once.
    pending_d    = load ? digits_in : pending_q;
    display_d    = wrap ? pending_d : display_q;
    frame_done_d = wrap;

    an_d  = '1;
    bcd_d = 4'hF;
    if ((state_q == SCAN) && digit_en[idx_q]) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      bcd_d = nib[idx_q];
`ifdef SEG_SCAN_LZB_EN
      if (lzb_blank) bcd_d = 4'hF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      display_q    <= '0;
      an_q         <= '1;
      bcd_q        <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign bcd_out    = bcd_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, SCAN_DIV=4 (16-cycle frame).
module tb_seg_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [4*DIGITS-1:0] digits_in;
  logic                load;
  logic [DIGITS-1:0]   digit_en;
  logic [3:0]          bcd_out;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  int checks   = 0;
  int failures = 0;

  seg_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .digit_en   (digit_en),
    .bcd_out    (bcd_out),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bcd for a zero nibble in slot s of an all-zero-above frame.
  function automatic logic [3:0] z(input int s);
    return (LZB && s > 0) ? 4'hF : 4'h0;
  endfunction

  // One digit slot: three lit cycles then one guard cycle. frame_done is
  // expected on the last lit cycle of slot 3 (the cycle after the wrap edge).
  // load_edge selects which of the four edges samples a load (-1 = none).
  task automatic run_slot(input int slot, input logic [3:0] exp_bcd, input bit lit,
                          input int load_edge, input logic [15:0] load_val);
    logic [3:0] exp_an;
    for (int e = 0; e < 4; e++) begin
      if (e == load_edge) begin
        digits_in = load_val;
        load      = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      if (e < 3) begin
        exp_an = lit ? ~(4'b0001 << slot) : 4'hF;
        chk($sformatf("an_s%0d_e%0d", slot, e), 32'(an), 32'(exp_an));
        chk($sformatf("bcd_s%0d_e%0d", slot, e), 32'(bcd_out), 32'(lit ? exp_bcd : 4'hF));
        chk($sformatf("fd_s%0d_e%0d", slot, e), 32'(frame_done), 32'((e == 2 && slot == 3) ? 1 : 0));
      end else begin
        chk($sformatf("an_guard_s%0d", slot), 32'(an), 32'hF);
        chk($sformatf("bcd_guard_s%0d", slot), 32'(bcd_out), 32'hF);
        chk($sformatf("fd_guard_s%0d", slot), 32'(frame_done), 32'h0);
      end
    end
    $display("slot %0d done: an=%b bcd=%h checks=%0d", slot, an, bcd_out, checks);
  endtask

  task automatic after_release;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("an_first_edge", 32'(an), 32'hF);
    chk("bcd_first_edge", 32'(bcd_out), 32'hF);
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    digit_en  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_bcd", 32'(bcd_out), 32'hF);
    chk("reset_fd", 32'(frame_done), 32'h0);
    after_release();

    // Frame A: display is zero; load 1234 during slot 1 must not tear.
    run_slot(0, z(0), 1, -1, 16'h0);
    run_slot(1, z(1), 1, 0, 16'h1234);
    run_slot(2, z(2), 1, -1, 16'h0);
    run_slot(3, z(3), 1, -1, 16'h0);

    // Frame B: 1234 committed; load 5678 exactly on the wrap edge.
    run_slot(0, 4'h4, 1, -1, 16'h0);
    run_slot(1, 4'h3, 1, -1, 16'h0);
    run_slot(2, 4'h2, 1, -1, 16'h0);
    run_slot(3, 4'h1, 1, 2, 16'h5678);

    // Frame C: bypass shows 5678 immediately; queue a non-BCD frame.
    run_slot(0, 4'h8, 1, -1, 16'h0);
    run_slot(1, 4'h7, 1, 0, 16'hBC3A);
    run_slot(2, 4'h6, 1, -1, 16'h0);
    run_slot(3, 4'h5, 1, -1, 16'h0);

    // Frame D: non-BCD nibbles pass through; queue 0070.
    run_slot(0, 4'hA, 1, -1, 16'h0);
    run_slot(1, 4'h3, 1, 0, 16'h0070);
    run_slot(2, 4'hC, 1, -1, 16'h0);
    run_slot(3, 4'hB, 1, -1, 16'h0);

    // Frame E: 0070, leading zeros blanked only with the feature enabled.
    run_slot(0, 4'h0, 1, -1, 16'h0);
    run_slot(1, 4'h7, 1, 0, 16'h4321);
    run_slot(2, z(2), 1, -1, 16'h0);
    run_slot(3, z(3), 1, -1, 16'h0);

    // Frame F: digits 0 and 2 disabled.
    digit_en = 4'b1010;
    run_slot(0, 4'hF, 0, -1, 16'h0);
    run_slot(1, 4'h2, 1, -1, 16'h0);
    run_slot(2, 4'hF, 0, -1, 16'h0);
    run_slot(3, 4'h4, 1, -1, 16'h0);

    // Frame G: reset asserted mid-SCAN in slot 1.
    digit_en = 4'b1111;
    run_slot(0, 4'h1, 1, -1, 16'h0);
    @(posedge clk);
    #1;
    chk("an_pre_reset", 32'(an), 32'hD);
    chk("bcd_pre_reset", 32'(bcd_out), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("an_async_reset", 32'(an), 32'hF);
    chk("bcd_async_reset", 32'(bcd_out), 32'hF);
    chk("fd_async_reset", 32'(frame_done), 32'h0);
    after_release();

    // Two frames of zeros: display and pending both cleared by reset.
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        run_slot(s, z(s), 1, -1, 16'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
